// File: rtl/div16u_seq.sv
// div16u_seq: sequential 16-bit by 8-bit unsigned restoring divider.
// One quotient bit per clock, MSB first; result registered and held until
// the next accepted start. A zero divisor short-circuits straight to DONE.
module div16u_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        ready,
  output logic        busy,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [15:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [7:0]  dvs;
  logic [8:0]  prem;     // partial remainder, one bit wider than the divisor
  logic [3:0]  cnt;
  logic [9:0]  step;     // {next partial remainder, quotient bit}

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [9:0] restore_step(input logic [8:0] pr,
                                              input logic       bitin,
                                              input logic [7:0] d);
    logic [9:0] trial;
    logic [9:0] diff;
    trial = {pr, bitin};
    diff  = trial - {2'b00, d};
    if (trial >= {2'b00, d})
      return {diff[8:0], 1'b1};
    else
      return {trial[8:0], 1'b0};
  endfunction

  // Combinational next step from the current partial remainder and dividend MSB.
  always_comb begin
    step = restore_step(prem, dvd[15], dvs);
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == 8'd0) begin
              state       <= DONE;
              quotient    <= 16'hFFFF;
              remainder   <= dividend[7:0];
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
              busy        <= 1'b0;
            end else begin
              state       <= BUSY;
              dvd         <= dividend;
              dvs         <= divisor;
              prem        <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              ready       <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        BUSY: begin
          prem <= step[9:1];
          dvd  <= {dvd[14:0], step[0]};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state     <= DONE;
            quotient  <= {dvd[14:0], step[0]};
            remainder <= step[8:1];
            ready     <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16u_seq.sv
// Testbench for div16u_seq: directed cases plus randomized operands checked
// against plain integer division.
module tb_div16u_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        ready;
  logic        busy;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  div16u_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation and check result, latency and handshake behaviour.
  // If intr_cyc >= 0, a second start with (a2,b2) is pulsed that many edges
  // after the sampling edge; it must be ignored.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input int intr_cyc, input logic [15:0] a2, input logic [7:0] b2);
    int          lat;
    bit          overlap;
    bit          busy_seen;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic [15:0] held_q;
    logic [7:0]  held_r;
    if (b == 8'd0) begin
      exp_q = 16'hFFFF;
      exp_r = a[7:0];
    end else begin
      exp_q = a / b;
      exp_r = a % b;
    end
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    lat       = 0;
    overlap   = 1'b0;
    busy_seen = 1'b0;
    while (!ready && lat < 40) begin
      if (busy) busy_seen = 1'b1;
      if (lat == intr_cyc) begin
        dividend = a2;
        divisor  = b2;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (ready && busy) overlap = 1'b1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, (b == 8'd0) ? 0 : 16);
    chk("ready", ready, 1'b1);
    chk("overlap", overlap, 1'b0);
    chk("busy_seen", busy_seen, (b != 8'd0));
    chk("quotient", quotient, exp_q);
    chk("remainder", remainder, exp_r);
    chk("div_by_zero", div_by_zero, (b == 8'd0));
    if (b != 8'd0)
      chk("identity", ((32'(quotient) * b + remainder) == a) && (remainder < b), 1'b1);
    held_q = quotient;
    held_r = remainder;
    repeat (2) @(negedge clk);
    chk("hold_q", quotient, held_q);
    chk("hold_r", remainder, held_r);
    chk("hold_ready", ready, 1'b1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'd45, 8'd3, -1, 16'd0, 8'd0);
    do_op(16'd65025, 8'd255, -1, 16'd0, 8'd0);
    do_op(16'd65535, 8'd1, -1, 16'd0, 8'd0);
    do_op(16'd100, 8'd7, -1, 16'd0, 8'd0);
    do_op(16'd1234, 8'd0, -1, 16'd0, 8'd0);
    do_op(16'd1000, 8'd9, 5, 16'd50, 8'd5);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    dividend = 16'd500;
    divisor  = 8'd4;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dbz", div_by_zero, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_ready", ready, 0);
    do_op(16'd500, 8'd4, -1, 16'd0, 8'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'd0;
        1: rb = 8'd255;
        2: ra = 16'd0;
        3: ra = 16'd65535;
        default: ;
      endcase
      do_op(ra, rb, -1, 16'd0, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div16u_seq.md
DIV16U_SEQ -- requirements
Module: div16u_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a division, sampled on the rising edge of clk.
REQ-005 dividend  input  16  unsigned dividend, sampled with start.
REQ-006 divisor  input  8  unsigned divisor, sampled with start.
REQ-007 quotient  output  16  registered unsigned quotient.
REQ-008 remainder  output  8  registered unsigned remainder.
REQ-009 ready  output  1  high while quotient, remainder and div_by_zero hold a completed result.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 div_by_zero  output  1  high with ready when the sampled divisor was 0.

Function
REQ-012 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 In IDLE or DONE, when start=1 and divisor!=0, the block SHALL latch dividend and divisor, clear the 9-bit partial remainder and the 4-bit iteration count, and enter BUSY; ready, div_by_zero -> 0, busy -> 1 on that same edge.
REQ-014 In BUSY, each cycle SHALL perform one restoring step MSB-first: shift {partial remainder, dividend bit} left by 1; if the result is >= divisor, subtract divisor and shift in quotient bit 1, otherwise shift in 0.
REQ-015 The partial remainder SHALL be 9 bits wide so that the shifted value never overflows before comparison.
REQ-016 After the 16th BUSY step the block SHALL enter DONE: quotient, remainder <= final values, ready=1, busy=0.
REQ-017 Latency: ready SHALL rise exactly 16 clock edges after the edge that sampled start (divisor!=0).
REQ-018 quotient and remainder SHALL remain stable from the edge ready rises until the next accepted start or reset.
REQ-019 start while BUSY SHALL be ignored; the operands and result in flight SHALL NOT be affected.
REQ-020 start in DONE SHALL be accepted per REQ-013, which allows back-to-back operations with one DONE cycle between them.
REQ-021 Divisor 0: when start=1 with divisor=0 in IDLE/DONE, the next edge SHALL enter DONE directly with quotient=16'hFFFF, remainder=dividend[7:0], div_by_zero=1, ready=1, busy=0; no BUSY cycles SHALL occur.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor!=0.
REQ-023 ready and busy SHALL never be high simultaneously.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0, and clear all internal registers.
REQ-025 Reset asserted mid-operation SHALL abandon the division, and no stale result SHALL appear after release.
REQ-026 The first start after reset is released SHALL be accepted on the first rising edge at which rst=0.

Verification
REQ-027 dividend=45, divisor=3, start pulse -> after 16 edges: ready=1, quotient=15, remainder=0, div_by_zero=0.
REQ-028 dividend=65025, divisor=255 -> quotient=255, remainder=0; dividend=65535, divisor=1 -> quotient=65535, remainder=0; dividend=100, divisor=7 -> quotient=14, remainder=2.
REQ-029 dividend=1234, divisor=0 -> one edge later: ready=1, div_by_zero=1, quotient=16'hFFFF, remainder=8'hD2; busy never asserts.
REQ-030 Start 1000/9, then pulse start with 50/5 at BUSY cycle 5 -> the result is quotient=111, remainder=1 at the original 16-edge mark; the second request is dropped.
REQ-031 Start 500/4, then assert rst asynchronously at BUSY cycle 8 -> all outputs are 0 immediately; after release, 500/4 completes with quotient=125, remainder=0 in 16 edges.
REQ-032 Random self-check: at least 1000 random dividend/divisor pairs, including divisor=0 and 255 and dividend=0 and 65535 -> REQ-022 holds and ready rises at the REQ-017 latency for every pair.
